// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-stage next-PC controller with boot delay, stall-pending redirects and halt/resume
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'd0,
    parameter logic [31:0] EXC_VECTOR  = 32'd1000,
    parameter logic [31:0] PC_STEP     = 32'd1,
    parameter int          BOOT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        clear,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        exception,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc_out,
    output logic        pc_valid,
    output logic        flush,
    output logic [1:0]  state_out
);

    localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          flush_q, flush_d;
    logic          pend_valid_q, pend_valid_d;
    logic          pend_jump_q, pend_jump_d;
    logic [31:0]   pend_target_q, pend_target_d;
    logic [CW-1:0] boot_cnt_q, boot_cnt_d;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            flush_q       <= 1'b0;
            pend_valid_q  <= 1'b0;
            pend_jump_q   <= 1'b0;
            pend_target_q <= 32'd0;
            boot_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            flush_q       <= flush_d;
            pend_valid_q  <= pend_valid_d;
            pend_jump_q   <= pend_jump_d;
            pend_target_q <= pend_target_d;
            boot_cnt_q    <= boot_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        flush_d       = 1'b0;
        pend_valid_d  = pend_valid_q;
        pend_jump_d   = pend_jump_q;
        pend_target_d = pend_target_q;
        boot_cnt_d    = boot_cnt_q;

        unique case (state_q)
            ST_BOOT: begin
                pc_d = RESET_PC;
                if (boot_cnt_q == BOOT_LAST) begin
                    state_d    = ST_RUN;
                    boot_cnt_d = '0;
                end else begin
                    boot_cnt_d = boot_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (exception) begin
                    pc_d         = EXC_VECTOR;
                    flush_d      = 1'b1;
                    pend_valid_d = 1'b0;
                end else if (stall) begin
                    // A pending jump is never displaced by a later branch.
                    if (jump) begin
                        pend_valid_d  = 1'b1;
                        pend_jump_d   = 1'b1;
                        pend_target_d = jump_target;
                    end else if (branch_taken && !(pend_valid_q && pend_jump_q)) begin
                        pend_valid_d  = 1'b1;
                        pend_jump_d   = 1'b0;
                        pend_target_d = branch_target;
                    end
                end else begin
                    pend_valid_d = 1'b0;
                    if (jump) begin
                        pc_d    = jump_target;
                        flush_d = 1'b1;
                    end else if (branch_taken) begin
                        pc_d    = branch_target;
                        flush_d = 1'b1;
                    end else if (pend_valid_q) begin
                        pc_d    = pend_target_q;
                        flush_d = 1'b1;
                    end else if (halt_req) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_q + PC_STEP;
                    end
                end
            end
            ST_HALT: begin
                if (exception) begin
                    pc_d         = EXC_VECTOR;
                    flush_d      = 1'b1;
                    pend_valid_d = 1'b0;
                    state_d      = ST_RUN;
                end else if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    assign pc_out    = pc_q;
    assign pc_valid  = (state_q == ST_RUN);
    assign flush     = flush_q;
    assign state_out = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic        exception = 1'b0;
    logic        halt_req = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        flush;
    logic [1:0]  state_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .clear        (clear),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .exception    (exception),
        .halt_req     (halt_req),
        .resume       (resume),
        .pc_out       (pc_out),
        .pc_valid     (pc_valid),
        .flush        (flush),
        .state_out    (state_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] epc, input logic evalid,
                           input logic eflush, input logic [1:0] est);
        chk({tag, "_pc"}, pc_out, epc);
        chk({tag, "_valid"}, {31'd0, pc_valid}, {31'd0, evalid});
        chk({tag, "_flush"}, {31'd0, flush}, {31'd0, eflush});
        chk({tag, "_state"}, {30'd0, state_out}, {30'd0, est});
    endtask

    initial begin
        // Test 1: reset, boot delay, sequential fetch
        step(); step();
        chk_all("reset", 32'd0, 1'b0, 1'b0, 2'b00);
        clear = 1'b0;
        step();
        chk_all("boot1", 32'd0, 1'b0, 1'b0, 2'b00);
        step();
        chk_all("run0", 32'd0, 1'b1, 1'b0, 2'b01);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("seq_pc", pc_out, 32'(i));
        end

        // Test 2: branch at pc=5
        branch_taken = 1'b1; branch_target = 32'd40;
        step();
        chk_all("br", 32'd40, 1'b1, 1'b1, 2'b01);
        branch_taken = 1'b0;
        step();
        chk_all("br_next", 32'd41, 1'b1, 1'b0, 2'b01);

        // Test 3: stall with branch then jump; jump wins on release
        jump = 1'b1; jump_target = 32'd7;
        step();
        chk_all("jmp7", 32'd7, 1'b1, 1'b1, 2'b01);
        jump = 1'b0; stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd20;
        step();
        chk_all("stall1", 32'd7, 1'b1, 1'b0, 2'b01);
        branch_taken = 1'b0; jump = 1'b1; jump_target = 32'd90;
        step();
        chk("stall2_pc", pc_out, 32'd7);
        jump = 1'b0;
        step();
        chk("stall3_pc", pc_out, 32'd7);
        stall = 1'b0;
        step();
        chk_all("release", 32'd90, 1'b1, 1'b1, 2'b01);
        step();
        chk_all("release_next", 32'd91, 1'b1, 1'b0, 2'b01);

        // Same-cycle jump+branch latches jump; later branch cannot overwrite it
        stall = 1'b1; jump = 1'b1; jump_target = 32'd200; branch_taken = 1'b1; branch_target = 32'd300;
        step();
        jump = 1'b0;
        step();
        branch_taken = 1'b0; stall = 1'b0;
        step();
        chk_all("pend_jump", 32'd200, 1'b1, 1'b1, 2'b01);

        // New redirect beats pending, pending cleared anyway
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd70;
        step();
        stall = 1'b0; branch_target = 32'd80;
        step();
        chk_all("new_wins", 32'd80, 1'b1, 1'b1, 2'b01);
        branch_taken = 1'b0;
        step();
        chk_all("pend_dropped", 32'd81, 1'b1, 1'b0, 2'b01);

        // Test 4: exception during stall with pending branch
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'd55;
        step();
        branch_taken = 1'b0; exception = 1'b1;
        step();
        chk_all("exc_stall", 32'd1000, 1'b1, 1'b1, 2'b01);
        exception = 1'b0; stall = 1'b0;
        step();
        chk_all("exc_next", 32'd1001, 1'b1, 1'b0, 2'b01);

        // Test 5: wrap, halt, ignored inputs, resume
        jump = 1'b1; jump_target = 32'hFFFF_FFFF;
        step();
        chk_all("jmp_max", 32'hFFFF_FFFF, 1'b1, 1'b1, 2'b01);
        jump = 1'b0;
        step();
        chk_all("wrap", 32'd0, 1'b1, 1'b0, 2'b01);
        step();
        chk("wrap_next", pc_out, 32'd1);
        halt_req = 1'b1;
        step();
        chk_all("halt", 32'd1, 1'b0, 1'b0, 2'b10);
        halt_req = 1'b0; jump = 1'b1; jump_target = 32'd500; stall = 1'b1;
        step();
        chk_all("halt_ignore", 32'd1, 1'b0, 1'b0, 2'b10);
        jump = 1'b0; stall = 1'b0; resume = 1'b1;
        step();
        chk_all("resume", 32'd1, 1'b1, 1'b0, 2'b01);
        resume = 1'b0;
        step();
        chk("resume_next", pc_out, 32'd2);

        // Exception and resume together from HALT
        halt_req = 1'b1;
        step();
        chk_all("halt2", 32'd2, 1'b0, 1'b0, 2'b10);
        halt_req = 1'b0; exception = 1'b1; resume = 1'b1;
        step();
        chk_all("halt_exc", 32'd1000, 1'b1, 1'b1, 2'b01);
        exception = 1'b0; resume = 1'b0;
        step();
        chk_all("halt_exc_next", 32'd1001, 1'b1, 1'b0, 2'b01);

        // Test 6: clear mid-stall with pending jump; redirects ignored in BOOT
        stall = 1'b1; jump = 1'b1; jump_target = 32'd300;
        step();
        jump = 1'b0;
        clear = 1'b1;
        #2;
        chk_all("async_clear", 32'd0, 1'b0, 1'b0, 2'b00);
        step();
        clear = 1'b0; stall = 1'b0; jump = 1'b1; jump_target = 32'd77;
        step();
        chk_all("boot_ignore", 32'd0, 1'b0, 1'b0, 2'b00);
        jump = 1'b0;
        step();
        chk_all("reboot_run", 32'd0, 1'b1, 1'b0, 2'b01);
        step();
        chk_all("reboot_next", 32'd1, 1'b1, 1'b0, 2'b01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
